window_3x3_gen: RTL and testbench

Streaming 3×3 neighbourhood generator that sits directly upstream of the median `filter` stage. It accepts one raster-order 8-bit pixel per cycle over a valid/ready handshake and keeps the two previous image rows in line buffers. For every interior pixel it presents the full 3×3 kernel on `out_0`..`out_8`, the same kernel ordering the filter consumes. This replaces random-access kernel fetch from image memory with a single-pass stream.

---
 rtl/median_pkg.sv | 22 ++
 rtl/line_buffer.sv | 23 ++
 rtl/window_3x3_gen.sv | 149 ++++++++++++++
 tb/tb_window_3x3_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared constants for the median filter pipeline: pixel width, default
// frame geometry, counter widths and kernel tap indices.
package median_pkg;

  localparam int PIX_W      = 8;
  localparam int WIDTH_DEF  = 430;
  localparam int LENGTH_DEF = 554;
  localparam int W_BITS     = $clog2(WIDTH_DEF);
  localparam int L_BITS     = $clog2(LENGTH_DEF);

  // Kernel taps are row-major: 0 top-left, 4 centre, 8 bottom-right.
  localparam int K_TAPS   = 9;
  localparam int K_TL     = 0;
  localparam int K_CENTER = 4;
  localparam int K_BR     = 8;

  // Flat tap index for kernel row r, column c.
  function automatic int kidx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of storage addressed by column. Read is combinational and
// sees the old contents when a write to the same address lands this cycle.
module line_buffer #(
  parameter int DEPTH = 430,
  parameter int PIX_W = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [PIX_W-1:0]         wdata_i,
  output logic [PIX_W-1:0]         rdata_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // Storage is deliberately not reset; stale rows are never exposed.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator. Two line buffers hold the previous
// rows; a 3x3 shift register holds the kernel and drives the outputs directly,
// so the kernel is frozen whenever no pixel is accepted.
module window_3x3_gen #(
  parameter int WIDTH  = median_pkg::WIDTH_DEF,
  parameter int LENGTH = median_pkg::LENGTH_DEF,
  parameter int PIX_W  = median_pkg::PIX_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic [PIX_W-1:0]              pix_data,
  output logic [PIX_W-1:0]              out_0,
  output logic [PIX_W-1:0]              out_1,
  output logic [PIX_W-1:0]              out_2,
  output logic [PIX_W-1:0]              out_3,
  output logic [PIX_W-1:0]              out_4,
  output logic [PIX_W-1:0]              out_5,
  output logic [PIX_W-1:0]              out_6,
  output logic [PIX_W-1:0]              out_7,
  output logic [PIX_W-1:0]              out_8,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [median_pkg::W_BITS-1:0] center_w,
  output logic [median_pkg::L_BITS-1:0] center_l,
  output logic                          frame_done
);
  import median_pkg::*;

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(LENGTH);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              win_valid_q, win_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [W_BITS-1:0] center_w_q;
  logic [L_BITS-1:0] center_l_q;
  logic [2:0][2:0][PIX_W-1:0]      sh_q;   // [kernel row][kernel column]
  logic [K_TAPS-1:0][PIX_W-1:0]    kern;
  logic [PIX_W-1:0]  lb0_rd, lb1_rd;
  logic              acc, consume, qual, last_col, last_row;

  // Single output register, no skid: the only comb path is win_ready.
  assign pix_ready = !win_valid_q || win_ready;

  // Next-state for position counters, window valid and end-of-frame pulse.
  always_comb begin
    acc          = pix_valid && pix_ready && !clear;
    consume      = win_valid_q && win_ready;
    last_col     = (col_q == CW'(WIDTH - 1));
    last_row     = (row_q == RW'(LENGTH - 1));
    qual         = acc && (int'(row_q) >= 2) && (int'(col_q) >= 2);
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = acc && last_col && last_row;
    if (acc) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    win_valid_d = win_valid_q;
    if (qual)         win_valid_d = 1'b1;
    else if (consume) win_valid_d = 1'b0;
  end

  // Row r-1 in lb0, row r-2 in lb1; both move down one row on every accept.
  line_buffer #(.DEPTH(WIDTH), .PIX_W(PIX_W)) u_lb0 (
    .clk     (clk),
    .we_i    (acc),
    .addr_i  (col_q),
    .wdata_i (pix_data),
    .rdata_o (lb0_rd)
  );

  line_buffer #(.DEPTH(WIDTH), .PIX_W(PIX_W)) u_lb1 (
    .clk     (clk),
    .we_i    (acc),
    .addr_i  (col_q),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  // Counters, kernel shift register and registered window sideband.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      center_w_q   <= '0;
      center_l_q   <= '0;
      sh_q         <= '0;
    end else if (clear) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      center_w_q   <= '0;
      center_l_q   <= '0;
      sh_q         <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      if (acc) begin
        for (int r = 0; r < 3; r++) begin
          sh_q[r][0] <= sh_q[r][1];
          sh_q[r][1] <= sh_q[r][2];
        end
        sh_q[0][2] <= lb1_rd;
        sh_q[1][2] <= lb0_rd;
        sh_q[2][2] <= pix_data;
      end
      if (qual) begin
        center_w_q <= W_BITS'(col_q) - W_BITS'(1);
        center_l_q <= L_BITS'(row_q) - L_BITS'(1);
      end
    end
  end

  // Flatten the shift register into row-major kernel order.
  for (genvar r = 0; r < 3; r++) begin : g_krow
    for (genvar c = 0; c < 3; c++) begin : g_kcol
      assign kern[kidx(r, c)] = sh_q[r][c];
    end
  end

  assign out_0      = kern[K_TL];
  assign out_1      = kern[1];
  assign out_2      = kern[2];
  assign out_3      = kern[3];
  assign out_4      = kern[K_CENTER];
  assign out_5      = kern[5];
  assign out_6      = kern[6];
  assign out_7      = kern[7];
  assign out_8      = kern[K_BR];
  assign win_valid  = win_valid_q;
  assign center_w   = center_w_q;
  assign center_l   = center_l_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen on a 5x4 frame: a frame-image model predicts every
// kernel from the accepted pixels; literal checks pin the ramp results.
module tb_window_3x3_gen;
  localparam int W = 5;
  localparam int L = 4;
  localparam int N = W * L;

  logic       clk = 0, rst_n = 1, clear = 0, pix_valid = 0, win_ready = 1;
  logic [7:0] pix_data = 0;
  logic       pix_ready, win_valid, frame_done;
  logic [7:0] out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7, out_8;
  logic [8:0] center_w;
  logic [9:0] center_l;

  window_3x3_gen #(.WIDTH(W), .LENGTH(L), .PIX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3), .out_4(out_4),
    .out_5(out_5), .out_6(out_6), .out_7(out_7), .out_8(out_8),
    .win_valid(win_valid), .win_ready(win_ready),
    .center_w(center_w), .center_l(center_l), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]      cl;
    logic [8:0]      cw;
    logic [8:0][7:0] k;
  } win_t;

  win_t dw;
  assign dw = {center_l, center_w, out_8, out_7, out_6, out_5, out_4,
               out_3, out_2, out_1, out_0};

  int   n_vec = 0, n_err = 0;
  int   cyc = 0, acc34_cyc = -1, fd_cyc = -5;
  logic [7:0] src[$];
  win_t got_q[$], ref_q[$];

  // model state: the current frame as an image plus the held window
  logic [7:0] img [N];
  int   m_k = 0;
  bit   m_wv = 0, m_fd = 0;
  win_t m_cur;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic win_t model_win(input int k);
    win_t w;
    int r = k / W, c = k % W;
    for (int i = 0; i < 9; i++)
      w.k[i] = img[(r - 2 + i / 3) * W + (c - 2 + i % 3)];
    w.cl = 10'(r - 1);
    w.cw = 9'(c - 1);
    return w;
  endfunction

  // compare process: checks the DUT against the model, then advances the model
  always @(negedge clk) begin
    bit acc, cons;
    cyc++;
    if (!rst_n) begin
      m_k = 0; m_wv = 0; m_fd = 0;
    end else begin
      chk("win_valid", win_valid, m_wv);
      chk("pix_ready", pix_ready, !m_wv || win_ready);
      chk("frame_done", frame_done, m_fd);
      if (m_wv) chk("window", dw, m_cur);
      acc  = pix_valid && (!m_wv || win_ready);
      cons = m_wv && win_ready;
      if (cons) got_q.push_back(dw);
      if (frame_done) fd_cyc = cyc;
      if (clear) begin
        m_k = 0; m_wv = 0; m_fd = 0;
      end else begin
        m_fd = acc && (m_k == N - 1);
        if (cons) m_wv = 0;
        if (acc) begin
          if (pix_data == 8'h34) acc34_cyc = cyc;
          img[m_k] = pix_data;
          if (m_k / W >= 2 && m_k % W >= 2) begin
            m_wv  = 1;
            m_cur = model_win(m_k);
          end
          m_k = (m_k + 1) % N;
        end
      end
    end
  end

  task automatic fill_ramp(input logic [7:0] base);
    for (int r = 0; r < L; r++)
      for (int c = 0; c < W; c++)
        src.push_back(8'(16 * r + c) + base);
  endtask

  // Feed src[0..nstop-1]; gap_pct = % idle cycles, wr_rand = random win_ready,
  // stall = cycles to hold win_ready low on the first window.
  task automatic run(input int gap_pct, input bit wr_rand, input int stall, input int nstop);
    int idx = 0, guard = 0, stall_left = stall;
    bit acc;
    while (idx < nstop && guard < 5000) begin
      pix_valid = ($urandom_range(99) >= gap_pct);
      pix_data  = src[idx];
      if (stall_left > 0 && win_valid) begin
        win_ready = 0;
        stall_left--;
      end else if (wr_rand) win_ready = 1'($urandom_range(1));
      else win_ready = 1;
      @(negedge clk);
      acc = pix_valid && pix_ready;
      if (stall > 0 && !win_ready) begin
        chk("stall_pix_ready", pix_ready, 0);
        chk("stall_out_4", out_4, 8'h11);
      end
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    if (guard >= 5000) begin
      n_vec++; n_err++;
      $display("FAIL run_timeout: accepted %0d required %0d", idx, nstop);
    end
    pix_valid = 0;
    win_ready = 1;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    bit allhi;
    #1 rst_n = 0;
    #1;
    chk("rst_win_valid", win_valid, 0);
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_out_0", out_0, 0);
    chk("rst_out_4", out_4, 0);
    chk("rst_out_8", out_8, 0);
    chk("rst_center_w", center_w, 0);
    chk("rst_center_l", center_l, 0);
    chk("rst_frame_done", frame_done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // gapless ramp frame
    src.delete(); fill_ramp(8'h00);
    got_q.delete();
    run(0, 0, 0, N); drain();
    chk("ramp_count", got_q.size(), 6);
    if (got_q.size() == 6) begin
      chk("first_cl", got_q[0].cl, 1);
      chk("first_cw", got_q[0].cw, 1);
      chk("first_out_0", got_q[0].k[0], 8'h00);
      chk("first_out_4", got_q[0].k[4], 8'h11);
      chk("first_out_8", got_q[0].k[8], 8'h22);
      chk("last_out_4", got_q[5].k[4], 8'h23);
    end
    chk("frame_done_delay", fd_cyc - acc34_cyc, 1);
    ref_q = got_q;

    // downstream stall on the first window
    got_q.delete();
    run(0, 0, 3, N); drain();
    chk("stall_count", got_q.size(), 6);
    for (int i = 0; i < ref_q.size() && i < got_q.size(); i++)
      chk("stall_seq", got_q[i], ref_q[i]);

    // random input gaps
    got_q.delete();
    run(40, 0, 0, N); drain();
    chk("gap_count", got_q.size(), 6);
    for (int i = 0; i < ref_q.size() && i < got_q.size(); i++)
      chk("gap_seq", got_q[i], ref_q[i]);

    // two back-to-back frames
    src.delete(); fill_ramp(8'h00); fill_ramp(8'h80);
    got_q.delete();
    run(0, 0, 0, 2 * N); drain();
    chk("two_frame_count", got_q.size(), 12);
    for (int i = 6; i < got_q.size() && i < 12; i++) begin
      allhi = 1;
      for (int j = 0; j < 9; j++) allhi &= got_q[i].k[j][7];
      chk("f2_only", allhi, 1);
      chk("f2_center", got_q[i].k[4], ref_q[i - 6].k[4] | 8'h80);
    end

    // async reset mid row 2, then a clean frame
    src.delete(); fill_ramp(8'h00);
    run(0, 0, 0, 13);
    #2 rst_n = 0;
    #1;
    chk("midrst_win_valid", win_valid, 0);
    chk("midrst_pix_ready", pix_ready, 1);
    chk("midrst_out_4", out_4, 0);
    chk("midrst_center_l", center_l, 0);
    chk("midrst_frame_done", frame_done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    got_q.delete();
    run(0, 0, 0, N); drain();
    chk("after_rst_count", got_q.size(), 6);
    if (got_q.size() > 0) chk("after_rst_out_4", got_q[0].k[4], 8'h11);

    // clear together with a pixel: the pixel is dropped
    run(0, 0, 0, 8);
    clear = 1; pix_valid = 1; pix_data = 8'hEE;
    @(posedge clk); #1;
    clear = 0; pix_valid = 0;
    got_q.delete();
    run(0, 0, 0, N); drain();
    chk("after_clr_count", got_q.size(), 6);
    if (got_q.size() > 0) chk("after_clr_out_4", got_q[0].k[4], 8'h11);

    // random pixels, gaps and backpressure over several frames
    src.delete();
    for (int i = 0; i < 6 * N; i++) src.push_back(8'($urandom));
    got_q.delete();
    run(30, 1, 0, 6 * N); drain();
    chk("rand_count", got_q.size(), 36);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
